rs_dec_out_framer: RTL

RS_DEC_OUT_FRAMER -- requirements
Module: rs_dec_out_framer

---
 rtl/rs_dec_out_framer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rs_dec_out_framer.sv
// RS decoder output framer: drops parity symbols and forwards each codeword's data bytes
// as a frame through a store-and-forward FIFO. Only whole, in-sequence frames are released.
module rs_dec_out_framer #(
    parameter int unsigned N_CW   = 132,
    parameter int unsigned K_DATA = 120,
    parameter int unsigned AW     = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        symb_out_val,
    input  logic [7:0]  symb_out_cnt,
    input  logic [7:0]  symb_corrected,
    input  logic        dout_rdy,
    output logic        dout_val,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [7:0]  dout,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        seq_err
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned IW    = $clog2(K_DATA);

    localparam logic [7:0]    LAST_DATA = 8'(K_DATA - 1);
    localparam logic [7:0]    LAST_SYMB = 8'(N_CW - 1);
    localparam logic [AW+1:0] DEPTH_W   = (AW + 2)'(DEPTH);
    localparam logic [AW+1:0] K_W       = (AW + 2)'(K_DATA);
    localparam logic [IW-1:0] LAST_RD   = IW'(K_DATA - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StSkip} state_e;

    state_e        state_q, state_d;
    logic [7:0]    exp_idx_q, exp_idx_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   commit_ptr_q, commit_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          seq_err_q, seq_err_d;

    logic [7:0]    mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    logic [AW:0]   used;
    logic [AW+1:0] free;
    logic          is_sop;
    logic          sop_rule;
    logic          xfer;

    // Occupancy counts committed data only; the in-progress frame was reserved at its sop.
    assign used   = commit_ptr_q - rd_ptr_q;
    assign free   = DEPTH_W - {1'b0, used};
    assign is_sop = (symb_out_cnt == 8'd0);

    always_comb begin
        state_d      = state_q;
        exp_idx_d    = exp_idx_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        seq_err_d    = seq_err_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q[AW-1:0];
        sop_rule     = 1'b0;

        if (symb_out_val) begin
            unique case (state_q)
                StIdle, StSkip: begin
                    sop_rule = is_sop;
                end
                StData: begin
                    if (symb_out_cnt == exp_idx_q) begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        exp_idx_d = exp_idx_q + 8'd1;
                        if (symb_out_cnt == LAST_DATA) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                            state_d      = StParity;
                        end
                    end else begin
                        // Erase the partial frame by rewinding to the last commit point.
                        seq_err_d = 1'b1;
                        wr_ptr_d  = commit_ptr_q;
                        if (is_sop) begin
                            sop_rule = 1'b1;
                        end else begin
                            state_d = StSkip;
                        end
                    end
                end
                StParity: begin
                    if (symb_out_cnt == exp_idx_q) begin
                        if (symb_out_cnt == LAST_SYMB) begin
                            exp_idx_d = 8'd0;
                            state_d   = StIdle;
                        end else begin
                            exp_idx_d = exp_idx_q + 8'd1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        if (is_sop) begin
                            sop_rule = 1'b1;
                        end else begin
                            state_d = StSkip;
                        end
                    end
                end
                default: ;
            endcase

            // Start of frame: admit only if a whole frame fits, so the FIFO cannot overflow.
            if (sop_rule) begin
                if (free >= K_W) begin
                    mem_we    = 1'b1;
                    mem_waddr = commit_ptr_q[AW-1:0];
                    wr_ptr_d  = commit_ptr_q + 1'b1;
                    exp_idx_d = 8'd1;
                    state_d   = StData;
                end else begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = StSkip;
                end
            end
        end
    end

    assign dout_val = (commit_ptr_q != rd_ptr_q);
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];
    assign dout_sop = dout_val & (rd_idx_q == '0);
    assign dout_eop = dout_val & (rd_idx_q == LAST_RD);
    assign xfer     = dout_val & dout_rdy;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        rd_idx_d = rd_idx_q;
        if (xfer) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_idx_d = (rd_idx_q == LAST_RD) ? '0 : rd_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= symb_corrected;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            exp_idx_q    <= 8'd0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_idx_q     <= '0;
            frame_cnt_q  <= 16'd0;
            drop_cnt_q   <= 16'd0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_idx_q    <= exp_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_idx_q     <= rd_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign seq_err   = seq_err_q;

endmodule
